ysyx_24090003_ifu: RTL and testbench
====================================

YSYX_24090003_IFU -- requirements
Module: ysyx_24090003_ifu

Interface
REQ-001 The block SHALL have parameter P_RESET_PC, default 32'h8000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port o_imem_req_valid, output, 1 bit: fetch request valid.
REQ-005 The block SHALL have port i_imem_req_ready, input, 1 bit: memory accepts the request.
REQ-006 The block SHALL have port o_imem_addr, output, 32 bits: fetch address, always equal to o_pc.
REQ-007 The block SHALL have port i_imem_rvalid, input, 1 bit: read data valid.
REQ-008 The block SHALL have port i_imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port o_inst_valid, output, 1 bit: an instruction is offered to the decoder.
REQ-010 The block SHALL have port i_inst_ready, input, 1 bit: the decoder accepts the offered instruction.
REQ-011 The block SHALL have port o_inst, output, 32 bits: the held instruction.
REQ-012 The block SHALL have port o_pc, output, 32 bits: PC of the held or in-flight instruction.
REQ-013 The block SHALL have port i_wb_valid, input, 1 bit: the execute stage has retired the instruction and redirect inputs are valid.
REQ-014 The block SHALL have port i_pc_update, input, 1 bit: take i_next_pc (the execute-stage PC update enable).
REQ-015 The block SHALL have port i_next_pc, input, 32 bits: redirect target from the execute stage.

Function
REQ-016 The FSM SHALL have four states: FETCH_REQ, FETCH_WAIT, DELIVER and EXEC_WAIT.
REQ-017 In FETCH_REQ, o_imem_req_valid SHALL be 1; on i_imem_req_ready=1 the FSM SHALL move to FETCH_WAIT.
REQ-018 In FETCH_WAIT, on i_imem_rvalid=1 the block SHALL latch i_imem_rdata into o_inst and move to DELIVER; the earliest response SHALL be the cycle after the request handshake.
REQ-019 i_imem_rvalid SHALL be ignored in every state except FETCH_WAIT.
REQ-020 In DELIVER, o_inst_valid SHALL be 1; on i_inst_ready=1 the FSM SHALL move to EXEC_WAIT.
REQ-021 o_inst and o_pc SHALL stay stable while o_inst_valid=1 and i_inst_ready=0.
REQ-022 In EXEC_WAIT, on i_wb_valid=1 the PC SHALL become i_next_pc if i_pc_update=1, otherwise PC+4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0), and the FSM SHALL move to FETCH_REQ.
REQ-023 i_wb_valid SHALL be ignored outside EXEC_WAIT.
REQ-024 From the FETCH_REQ handshake to the following FETCH_REQ, minimum latency SHALL be 4 cycles: one cycle each in FETCH_WAIT, DELIVER and EXEC_WAIT with zero-wait inputs.
REQ-025 o_imem_req_valid, once asserted, SHALL NOT deassert until i_imem_req_ready=1, except on reset.
REQ-026 Exactly one instruction SHALL be in flight at any time.

Reset
REQ-027 On i_rst=1 the block SHALL set the PC to P_RESET_PC, the state to FETCH_REQ, o_inst to 0 and o_inst_valid to 0.
REQ-028 During a reset cycle o_imem_req_valid SHALL be 0; it SHALL assert on the first cycle after i_rst deasserts.
REQ-029 Reset in any state SHALL abandon the in-flight fetch; a late i_imem_rvalid SHALL be ignored per REQ-019.
REQ-030 Reset SHALL take priority over every simultaneous handshake event.

Configuration
REQ-031 With YSYX_24090003_IFU_ALIGN_CHECK_EN defined, the block SHALL add output o_fetch_misalign (1 bit, reset 0).
REQ-032 Under that macro, if i_wb_valid=1 with i_pc_update=1 and i_next_pc[1:0]!=0, the PC SHALL still load i_next_pc, o_fetch_misalign SHALL assert and stay set, and the FSM SHALL halt in EXEC_WAIT until reset.
REQ-033 Without the macro, the port SHALL be absent and no alignment check SHALL be made.

Verification
REQ-034 Reset release, ready=1, rvalid=1 one cycle later with rdata=32'h00000013 -> o_imem_addr=32'h80000000; o_inst_valid=1 with o_inst=32'h00000013 after 2 cycles.
REQ-035 Decoder holds i_inst_ready=0 for 5 cycles -> o_inst and o_pc unchanged; the FSM advances only on i_inst_ready=1.
REQ-036 i_wb_valid=1 with i_pc_update=0 at PC 32'h80000004 -> next request address 32'h80000008.
REQ-037 i_wb_valid=1 with i_pc_update=1 and i_next_pc=32'h80000100 -> next request address 32'h80000100; i_wb_valid pulses in DELIVER are ignored.
REQ-038 i_rst asserted in FETCH_WAIT, then rvalid=1 one cycle later -> response dropped, o_inst_valid=0, refetch from 32'h80000000.
REQ-039 With the macro defined, i_next_pc=32'h80000102 -> o_fetch_misalign=1 and no further request until reset.

Source files
------------

// File: rtl/ysyx_24090003_ifu.sv
// ============================================================================
// Module   : ysyx_24090003_ifu
// Brief    : Instruction fetch unit for a single-issue core.
//            The unit fetches one instruction at a time and offers it to the
//            decoder. It then waits for the execute stage to retire that
//            instruction before it fetches the next one. Only one
//            instruction is ever in flight.
//
// Ports    : i_clk            - clock; all state updates on the rising edge
//            i_rst            - synchronous, active-high reset
//            o_imem_req_valid - fetch request valid
//            i_imem_req_ready - memory accepts the request
//            o_imem_addr      - fetch address (always equal to o_pc)
//            i_imem_rvalid    - read data valid
//            i_imem_rdata     - fetched instruction word
//            o_inst_valid     - instruction offered to the decoder
//            i_inst_ready     - decoder accepts the instruction
//            o_inst           - held instruction
//            o_pc             - PC of the held or in-flight instruction
//            i_wb_valid       - execute stage retired; redirect inputs valid
//            i_pc_update      - take i_next_pc instead of PC+4
//            i_next_pc        - redirect target
//            o_fetch_misalign - sticky misaligned-redirect flag
//                               (present only with the macro below)
//
// Config   : YSYX_24090003_IFU_ALIGN_CHECK_EN
//            When defined, a redirect to a target that is not word aligned
//            sets o_fetch_misalign. The unit then halts in EXEC_WAIT until
//            the next reset.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24090003_ifu #(
    parameter logic [31:0] P_RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_wb_valid,
    input  logic        i_pc_update,
    input  logic [31:0] i_next_pc
`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
    ,
    output logic        o_fetch_misalign
`endif
);

    localparam logic [1:0] c_FETCH_REQ  = 2'd0;
    localparam logic [1:0] c_FETCH_WAIT = 2'd1;
    localparam logic [1:0] c_DELIVER    = 2'd2;
    localparam logic [1:0] c_EXEC_WAIT  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] w_redirect_pc;
    logic        w_wb_fire;
    logic        w_halted;
    logic        w_misalign_now;

`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
    logic r_fetch_misalign;

    // Once the flag is set, retirement is no longer accepted. This freezes
    // the unit in EXEC_WAIT until the next reset.
    assign w_halted         = r_fetch_misalign;
    assign w_misalign_now   = w_wb_fire && i_pc_update && (i_next_pc[1:0] != 2'b00);
    assign o_fetch_misalign = r_fetch_misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_misalign <= 1'b0;
        end else if (w_misalign_now) begin
            r_fetch_misalign <= 1'b1;
        end
    end
`else
    assign w_halted       = 1'b0;
    assign w_misalign_now = 1'b0;
`endif

    // Retirement only counts in EXEC_WAIT. wb pulses in other states are
    // dropped here.
    assign w_wb_fire     = (r_state == c_EXEC_WAIT) && i_wb_valid && !w_halted;
    assign w_redirect_pc = i_pc_update ? i_next_pc : (r_pc + 32'd4);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH_REQ:  if (i_imem_req_ready) w_next_state = c_FETCH_WAIT;
            c_FETCH_WAIT: if (i_imem_rvalid)    w_next_state = c_DELIVER;
            c_DELIVER:    if (i_inst_ready)     w_next_state = c_EXEC_WAIT;
            c_EXEC_WAIT:  if (w_wb_fire && !w_misalign_now) w_next_state = c_FETCH_REQ;
            default:      w_next_state = c_FETCH_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_FETCH_REQ;
            r_pc    <= P_RESET_PC;
            r_inst  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            // The PC still loads a misaligned target, so software can see
            // where the unit halted.
            if (w_wb_fire) begin
                r_pc <= w_redirect_pc;
            end
            // Read data is taken only while a response is expected. A
            // response that arrives late after a reset is ignored.
            if ((r_state == c_FETCH_WAIT) && i_imem_rvalid) begin
                r_inst <= i_imem_rdata;
            end
        end
    end

    // The request is masked during a reset cycle. The state is already
    // FETCH_REQ by then, so the request appears on the first cycle after
    // release.
    assign o_imem_req_valid = (r_state == c_FETCH_REQ) && !i_rst;
    assign o_imem_addr      = r_pc;
    assign o_pc             = r_pc;
    assign o_inst           = r_inst;
    assign o_inst_valid     = (r_state == c_DELIVER);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24090003_ifu.sv
// ============================================================================
// Module   : tb_ysyx_24090003_ifu
// Brief    : Self-checking bench for ysyx_24090003_ifu. The bench acts as the
//            instruction memory, the decoder and the execute stage. It uses
//            a vector table and then randomized transactions. The next fetch
//            address is predicted with plain PC arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24090003_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_valid;
    logic        pc_update;
    logic [31:0] next_pc;
`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_24090003_ifu #(.P_RESET_PC(32'h8000_0000)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_addr      (imem_addr),
        .i_imem_rvalid    (imem_rvalid),
        .i_imem_rdata     (imem_rdata),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_pc             (pc),
        .i_wb_valid       (wb_valid),
        .i_pc_update      (pc_update),
        .i_next_pc        (next_pc)
`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
        ,
        .o_fetch_misalign (fetch_misalign)
`endif
    );

    typedef struct {
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic        upd;
        logic [31:0] npc;
        int          rdy_dly;
        int          rsp_dly;
        int          ins_dly;
        int          wb_dly;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction: request, response, delivery and retirement.
    // Stray rvalid and wb pulses are injected in the states that must
    // ignore them.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data,
                             input logic upd, input logic [31:0] npc,
                             input int rdy_dly, input int rsp_dly,
                             input int ins_dly, input int wb_dly, input bit first);
        int waits;
        waits = 0;
        while (!imem_req_valid && waits < 10) begin
            step();
            waits++;
        end
        check("req_valid", {31'd0, imem_req_valid}, 32'd1);
        if (!first) check("req_latency", waits, 32'd0);
        check("req_addr", imem_addr, exp_addr);
        check("req_pc", pc, exp_addr);
        for (int k = 0; k < rdy_dly; k++) begin
            step();
            check("req_hold", {31'd0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("fw_req_low", {31'd0, imem_req_valid}, 32'd0);
        for (int k = 0; k < rsp_dly; k++) begin
            wb_valid = 1'b1; pc_update = 1'b1; next_pc = 32'h1234_5670;
            step();
            check("fw_no_inst", {31'd0, inst_valid}, 32'd0);
        end
        wb_valid = 1'b0; pc_update = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = data;
        step();
        imem_rvalid = 1'b0; imem_rdata = ~data;
        check("dlv_valid", {31'd0, inst_valid}, 32'd1);
        check("dlv_inst", inst, data);
        check("dlv_pc", pc, exp_addr);
`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
        check("dlv_misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
        for (int k = 0; k < ins_dly; k++) begin
            wb_valid = 1'b1; pc_update = 1'b1; next_pc = 32'h0BAD_0000;
            imem_rvalid = 1'b1;
            step();
            check("hold_valid", {31'd0, inst_valid}, 32'd1);
            check("hold_inst", inst, data);
            check("hold_pc", pc, exp_addr);
        end
        wb_valid = 1'b0; pc_update = 1'b0; imem_rvalid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("exec_no_inst", {31'd0, inst_valid}, 32'd0);
        check("exec_no_req", {31'd0, imem_req_valid}, 32'd0);
        for (int k = 0; k < wb_dly; k++) begin
            step();
            check("exec_wait_req", {31'd0, imem_req_valid}, 32'd0);
            check("exec_wait_pc", pc, exp_addr);
        end
        wb_valid = 1'b1; pc_update = upd; next_pc = npc;
        step();
        wb_valid = 1'b0; pc_update = 1'b0;
    endtask

    initial begin
        logic [31:0] model_pc;
        logic        r_upd;
        logic [31:0] r_npc;

        tbl[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 32'h0,          0, 0, 0, 0};
        tbl[1] = '{32'h8000_0004, 32'h0010_0093, 1'b0, 32'h0,          2, 3, 5, 1};
        tbl[2] = '{32'h8000_0008, 32'h0020_0113, 1'b1, 32'h8000_0100,  0, 1, 2, 0};
        tbl[3] = '{32'h8000_0100, 32'hFFDF_F06F, 1'b1, 32'hFFFF_FFFC,  1, 0, 0, 3};
        tbl[4] = '{32'hFFFF_FFFC, 32'h0000_8067, 1'b0, 32'h0,          0, 2, 1, 0};
        tbl[5] = '{32'h0000_0000, 32'h0040_0193, 1'b1, 32'h8000_0000,  3, 0, 0, 2};

        rst = 1'b1; imem_req_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        inst_ready = 1'b0; wb_valid = 1'b0; pc_update = 1'b0; next_pc = 32'd0;
        repeat (3) step();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
        check("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            fetch_one(tbl[i].exp_addr, tbl[i].rdata, tbl[i].upd, tbl[i].npc,
                      tbl[i].rdy_dly, tbl[i].rsp_dly, tbl[i].ins_dly, tbl[i].wb_dly, i == 0);
        end

        // Randomized transactions. The next PC is the redirect target or
        // PC+4, taken modulo 2^32.
        model_pc = 32'h8000_0000;
        for (int i = 0; i < 40; i++) begin
            r_upd = 1'($urandom_range(0, 1));
            r_npc = {$urandom() & 32'hFFFF_FFFC};
            fetch_one(model_pc, $urandom(), r_upd, r_npc,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            model_pc = r_upd ? r_npc : model_pc + 32'd4;
        end
        // Leave the unit at a known PC before the reset tests.
        fetch_one(model_pc, 32'h0000_0013, 1'b1, 32'h8000_0040, 0, 0, 0, 0, 1'b0);

        // Reset during FETCH_WAIT. A late response must be dropped.
        check("pre_rst_addr", imem_addr, 32'h8000_0040);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        check("fwrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("fwrst_pc", pc, 32'h8000_0000);
        check("fwrst_inst", inst, 32'd0);
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        step();
        imem_rvalid = 1'b0;
        check("late_rsp_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("late_rsp_inst", inst, 32'd0);
        check("refetch_addr", imem_addr, 32'h8000_0000);
        fetch_one(32'h8000_0000, 32'h0000_0013, 1'b1, 32'h8000_0080, 0, 0, 0, 0, 1'b1);

        // Reset wins over a simultaneous decoder handshake in DELIVER.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
        step();
        imem_rvalid = 1'b0;
        check("prio_dlv_valid", {31'd0, inst_valid}, 32'd1);
        check("prio_dlv_pc", pc, 32'h8000_0080);
        inst_ready = 1'b1; rst = 1'b1;
        step();
        inst_ready = 1'b0; rst = 1'b0;
        #1;
        check("prio_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("prio_pc", pc, 32'h8000_0000);
        check("prio_req_valid", {31'd0, imem_req_valid}, 32'd1);

`ifdef YSYX_24090003_IFU_ALIGN_CHECK_EN
        // A misaligned redirect latches the flag and halts fetching.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        wb_valid = 1'b1; pc_update = 1'b1; next_pc = 32'h8000_0102;
        step();
        wb_valid = 1'b0; pc_update = 1'b0;
        check("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        check("mis_pc", pc, 32'h8000_0102);
        for (int k = 0; k < 10; k++) begin
            wb_valid = 1'b1; pc_update = k[0]; next_pc = 32'h8000_0200;
            step();
            check("mis_halt_req", {31'd0, imem_req_valid}, 32'd0);
            check("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
        end
        wb_valid = 1'b0; pc_update = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mis_rst_flag", {31'd0, fetch_misalign}, 32'd0);
        check("mis_rst_req", {31'd0, imem_req_valid}, 32'd1);
        check("mis_rst_addr", imem_addr, 32'h8000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
